// File: rtl/ofdm_pkg.sv
// Shared OFDM framing definitions used by the cyclic-prefix inserter and stripper.
//   N_CP   : prefix length in words
//   N_BODY : body length in words
//   W      : word width in bits
//   SYM_W  : full serialized symbol width in bits (prefix + body)
//   state_t: framing FSM states
package ofdm_pkg;
  localparam int N_CP   = 3;
  localparam int N_BODY = 16;
  localparam int W      = 16;
  localparam int SYM_W  = (N_CP + N_BODY) * W;

  typedef enum logic [1:0] {
    S_CP,
    S_BODY,
    S_OUT
  } state_t;
endpackage

// File: rtl/cyclic_prefix_strip_256_cmp.sv
// cp_word_cmp: holds the received cyclic-prefix words and a sticky mismatch flag.
// Ports:
//   clk, rst_n    : clock, synchronous active-low reset (clears the flag only)
//   store         : write data into cp_buf[store_idx]
//   store_idx     : prefix slot to write
//   cmp           : compare data against cp_buf[cmp_idx]; a mismatch sets err
//   cmp_idx       : prefix slot to compare against
//   clr           : clear the sticky flag (takes priority over cmp)
//   data          : received word
//   err           : registered sticky mismatch flag
module cp_word_cmp
  import ofdm_pkg::*;
#(
  parameter  int N_CP = ofdm_pkg::N_CP,
  parameter  int W    = ofdm_pkg::W,
  localparam int IW   = (N_CP > 1) ? $clog2(N_CP) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          store,
  input  logic [IW-1:0] store_idx,
  input  logic          cmp,
  input  logic [IW-1:0] cmp_idx,
  input  logic          clr,
  input  logic [W-1:0]  data,
  output logic          err
);

  logic [W-1:0] cp_buf [N_CP];

  // Prefix storage is pure data and is not reset.
  always_ff @(posedge clk) begin
    if (store) cp_buf[store_idx] <= data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                               err <= 1'b0;
    else if (clr)                             err <= 1'b0;
    else if (cmp && (data != cp_buf[cmp_idx])) err <= 1'b1;
  end

endmodule

// File: rtl/cyclic_prefix_strip_256.sv
// cyclic_prefix_strip_256: removes the cyclic prefix from a serialized OFDM
// symbol, checks it against the body tail and presents the body as two
// half-vectors for the demapper.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   in_data/in_valid    : received word stream; in_ready is registered
//   in_sof              : first prefix word marker, forces resync mid-symbol
//   phase               : body words 0..N_BODY/2-1, word 0 in the top bits
//   quad                : body words N_BODY/2..N_BODY-1
//   out_valid/out_ready : symbol handshake; phase/quad/cp_err held while valid
//   cp_err              : prefix mismatch for the presented symbol
//   align_err           : one-cycle pulse after a resync
//   sym_cnt             : delivered-symbol counter, wraps
module cyclic_prefix_strip_256
  import ofdm_pkg::*;
#(
  parameter int N_CP   = ofdm_pkg::N_CP,
  parameter int N_BODY = ofdm_pkg::N_BODY,
  parameter int W      = ofdm_pkg::W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [W-1:0]            in_data,
  input  logic                    in_valid,
  input  logic                    in_sof,
  output logic                    in_ready,
  output logic [N_BODY*W/2-1:0]   phase,
  output logic [N_BODY*W/2-1:0]   quad,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    cp_err,
  output logic                    align_err,
  output logic [15:0]             sym_cnt
);

  localparam int BW    = N_BODY * W;
  localparam int HW    = BW / 2;
  localparam int IDX_W = $clog2(N_BODY);
  localparam int CP_IW = (N_CP > 1) ? $clog2(N_CP) : 1;
  // Body words from this index onward repeat the prefix.
  localparam int TAIL0 = N_BODY - N_CP;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [BW-1:0]    body;

  logic             acc;
  logic             resync;
  logic             store;
  logic             cmp;
  logic             clr;
  logic [IDX_W-1:0] tail_idx;
  logic [CP_IW-1:0] store_idx;
  logic             err;

  assign acc    = in_valid && in_ready;
  assign resync = acc && in_sof &&
                  ((state == S_BODY) || ((state == S_CP) && (idx != '0)));

  // A resyncing word always lands in prefix slot 0.
  assign store     = acc && ((state == S_CP) || resync);
  assign store_idx = in_sof ? '0 : idx[CP_IW-1:0];
  assign tail_idx  = idx - IDX_W'(TAIL0);
  assign cmp       = acc && (state == S_BODY) && !in_sof && (idx >= IDX_W'(TAIL0));
  assign clr       = resync || ((state == S_OUT) && out_ready);

  cp_word_cmp #(
    .N_CP (N_CP),
    .W    (W)
  ) u_cmp (
    .clk       (clk),
    .rst_n     (rst_n),
    .store     (store),
    .store_idx (store_idx),
    .cmp       (cmp),
    .cmp_idx   (tail_idx[CP_IW-1:0]),
    .clr       (clr),
    .data      (in_data),
    .err       (err)
  );

  // The flag stops moving once the last body word is in, so it is stable in S_OUT.
  assign cp_err = err;
  assign phase  = body[BW-1 -: HW];
  assign quad   = body[HW-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_CP;
      idx       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      align_err <= 1'b0;
      sym_cnt   <= '0;
      body      <= '0;
    end else begin
      align_err <= 1'b0;
      if (resync) begin
        state     <= S_CP;
        idx       <= IDX_W'(1);
        align_err <= 1'b1;
      end else begin
        case (state)
          S_CP: begin
            in_ready <= 1'b1;
            if (acc) begin
              if (idx == IDX_W'(N_CP - 1)) begin
                state <= S_BODY;
                idx   <= '0;
              end else begin
                idx <= idx + IDX_W'(1);
              end
            end
          end
          S_BODY: begin
            if (acc) begin
              body <= {body[BW-W-1:0], in_data};
              if (idx == IDX_W'(N_BODY - 1)) begin
                state     <= S_OUT;
                idx       <= '0;
                in_ready  <= 1'b0;
                out_valid <= 1'b1;
              end else begin
                idx <= idx + IDX_W'(1);
              end
            end
          end
          S_OUT: begin
            if (out_ready) begin
              state     <= S_CP;
              idx       <= '0;
              in_ready  <= 1'b1;
              out_valid <= 1'b0;
              sym_cnt   <= sym_cnt + 16'd1;
            end
          end
          default: begin
            state <= S_CP;
            idx   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cyclic_prefix_strip_256.sv
module tb_cyclic_prefix_strip_256;

  logic         clk;
  logic         rst_n;
  logic [15:0]  in_data;
  logic         in_valid;
  logic         in_sof;
  logic         in_ready;
  logic [127:0] phase;
  logic [127:0] quad;
  logic         out_valid;
  logic         out_ready;
  logic         cp_err;
  logic         align_err;
  logic [15:0]  sym_cnt;

  cyclic_prefix_strip_256 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_ready  (in_ready),
    .phase     (phase),
    .quad      (quad),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .cp_err    (cp_err),
    .align_err (align_err),
    .sym_cnt   (sym_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] phase;
    logic [127:0] quad;
    int           bad_idx;
    logic [15:0]  bad_val;
    logic         exp_err;
  } vec_t;

  typedef struct {
    logic [127:0] phase;
    logic [127:0] quad;
    logic         err;
  } exp_t;

  int          n_cmp = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          n_align = 0;
  int          m_align = 0;
  int          m_sym = 0;
  logic [15:0] cur [$];
  exp_t        exp_q [$];
  int          hs_t [$];
  logic        rand_done;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference model: a symbol is the last run of 19 accepted words; a marked
  // word arriving while a partial symbol exists throws that partial away.
  task automatic model_word(input logic [15:0] w, input logic sof);
    exp_t e;
    if (sof && cur.size() != 0) begin
      cur.delete();
      m_align++;
    end
    cur.push_back(w);
    if (cur.size() == 19) begin
      e.phase = '0;
      e.quad  = '0;
      for (int i = 0; i < 8; i++) begin
        e.phase = {e.phase[111:0], cur[3 + i]};
        e.quad  = {e.quad[111:0],  cur[11 + i]};
      end
      e.err = (cur[0] != cur[16]) || (cur[1] != cur[17]) || (cur[2] != cur[18]);
      exp_q.push_back(e);
      cur.delete();
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: sample on the falling edge, away from register updates.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!rst_n) begin
      cur.delete();
      exp_q.delete();
      m_sym = 0;
    end else begin
      if (align_err) n_align++;
      if (in_valid && in_ready) model_word(in_data, in_sof);
      if (out_valid && out_ready) begin
        hs_t.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL out_unexpected: actual phase=%0h required no output", phase);
        end else begin
          e = exp_q.pop_front();
          chk("mon_phase", phase, e.phase);
          chk("mon_quad", quad, e.quad);
          chk("mon_cp_err", cp_err, e.err);
          chk("mon_sym_cnt", sym_cnt, m_sym[15:0]);
          m_sym++;
        end
      end
    end
  end

  function automatic void build_words(input logic [127:0] p, input logic [127:0] q,
                                      output logic [15:0] w [19]);
    logic [255:0] b;
    b = {p, q};
    for (int i = 0; i < 16; i++) w[3 + i] = b[255 - 16*i -: 16];
    for (int i = 0; i < 3; i++)  w[i] = w[16 + i];
  endfunction

  task automatic send_word(input logic [15:0] w, input logic sof);
    int n;
    n = 0;
    in_data  = w;
    in_sof   = sof;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout: actual in_ready=0 required 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic send_symbol(input logic [127:0] p, input logic [127:0] q, input int bad_idx,
                             input logic [15:0] bad_val, input int nwords, input logic sof0,
                             input logic gaps);
    logic [15:0] w [19];
    build_words(p, q, w);
    if (bad_idx >= 0) w[bad_idx] = bad_val;
    for (int i = 0; i < nwords; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      send_word(w[i], (i == 0) ? sof0 : 1'b0);
    end
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    in_sof    = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic take_output();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  vec_t        vt [4];
  logic [15:0] vals [4];

  initial begin
    logic [15:0] w [19];
    int          n;
    logic [127:0] p, q;
    int          bad, nw;
    logic        force_sof, s0;

    vals[0] = 16'h0005; vals[1] = 16'h000a; vals[2] = 16'h000f; vals[3] = 16'h0014;
    vt[0] = '{phase: {8{16'h000a}}, quad: {8{16'h0014}}, bad_idx: -1, bad_val: 16'h0000, exp_err: 1'b0};
    vt[1] = '{phase: {8{16'h000a}}, quad: {8{16'h0005}}, bad_idx: 1,  bad_val: 16'h0013, exp_err: 1'b1};
    vt[2] = '{phase: {8{16'h000f}}, quad: {8{16'h0005}}, bad_idx: -1, bad_val: 16'h0000, exp_err: 1'b0};
    vt[3] = '{phase: 128'h0001_0002_0003_0004_0005_0006_0007_0008,
              quad:  128'h0009_000a_000b_000c_000d_000e_000f_0010,
              bad_idx: 0, bad_val: 16'hbeef, exp_err: 1'b1};

    in_data   = '0;
    in_valid  = 1'b0;
    in_sof    = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_cp_err", cp_err, 0);
    chk("rst_align_err", align_err, 0);
    chk("rst_sym_cnt", sym_cnt, 0);
    chk("rst_phase", phase, 0);
    chk("rst_quad", quad, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("in_ready_after_rst", in_ready, 1);

    // Table vectors: single symbols, output held until taken.
    for (int i = 0; i < 4; i++) begin
      send_symbol(vt[i].phase, vt[i].quad, vt[i].bad_idx, vt[i].bad_val, 19, 1'b1, 1'b0);
      chk("tbl_out_valid", out_valid, 1);
      chk("tbl_in_ready", in_ready, 0);
      chk("tbl_phase", phase, vt[i].phase);
      chk("tbl_quad", quad, vt[i].quad);
      chk("tbl_cp_err", cp_err, vt[i].exp_err);
      take_output();
      chk("tbl_out_valid_drop", out_valid, 0);
      chk("tbl_sym_cnt", sym_cnt, i + 1);
    end

    // Downstream stall for 10 cycles with input pressure.
    send_symbol(128'h1234_5678_9abc_def0_0f1e_2d3c_4b5a_6978,
                128'hfedc_ba98_7654_3210_a5a5_5a5a_c3c3_3c3c, -1, 0, 19, 1'b1, 1'b0);
    in_data  = 16'hdead;
    in_sof   = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_out_valid", out_valid, 1);
      chk("stall_phase", phase, 128'h1234_5678_9abc_def0_0f1e_2d3c_4b5a_6978);
      chk("stall_quad", quad, 128'hfedc_ba98_7654_3210_a5a5_5a5a_c3c3_3c3c);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    take_output();
    chk("stall_released", out_valid, 0);
    chk("stall_sym_cnt", sym_cnt, 5);

    // Back-to-back: all 16 combinations, 20 cycles apart.
    do_reset();
    hs_t.delete();
    out_ready = 1'b1;
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        send_symbol({8{vals[a]}}, {8{vals[b]}}, -1, 0, 19, 1'b1, 1'b0);
    n = 0;
    while (hs_t.size() < 16 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("b2b_count", hs_t.size(), 16);
    for (int i = 1; i < hs_t.size(); i++)
      chk("b2b_spacing", hs_t[i] - hs_t[i-1], 20);
    chk("b2b_sym_cnt", sym_cnt, 16);

    // Resync at body word 5.
    do_reset();
    n_align = 0;
    send_symbol({8{16'h1111}}, {8{16'h2222}}, -1, 0, 8, 1'b1, 1'b0);
    build_words({8{16'h000a}}, {8{16'h000f}}, w);
    send_word(w[0], 1'b1);
    chk("sof_align_pulse", align_err, 1);
    send_word(w[1], 1'b0);
    chk("sof_align_drop", align_err, 0);
    for (int i = 2; i < 19; i++) send_word(w[i], 1'b0);
    chk("sof_out_valid", out_valid, 1);
    chk("sof_phase", phase, {8{16'h000a}});
    chk("sof_quad", quad, {8{16'h000f}});
    chk("sof_cp_err", cp_err, 0);
    take_output();
    chk("sof_align_count", n_align, 1);
    chk("sof_sym_cnt", sym_cnt, 1);

    // Reset at body word 9.
    do_reset();
    send_symbol({8{16'h3333}}, {8{16'h4444}}, -1, 0, 12, 1'b1, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_sym_cnt", sym_cnt, 0);
    send_symbol({8{16'h0005}}, {8{16'h0014}}, -1, 0, 19, 1'b1, 1'b0);
    chk("midrst_new_valid", out_valid, 1);
    chk("midrst_new_phase", phase, {8{16'h0005}});
    chk("midrst_new_quad", quad, {8{16'h0014}});
    chk("midrst_new_cp_err", cp_err, 0);
    take_output();
    chk("midrst_new_sym_cnt", sym_cnt, 1);

    // Randomized traffic against the reference model.
    do_reset();
    n_align   = 0;
    m_align   = 0;
    rand_done = 1'b0;
    force_sof = 1'b0;
    fork
      begin
        for (int s = 0; s < 40; s++) begin
          p   = {$urandom, $urandom, $urandom, $urandom};
          q   = {$urandom, $urandom, $urandom, $urandom};
          bad = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : -1;
          nw  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 18)) : 19;
          s0  = force_sof ? 1'b1 : ($urandom_range(0, 3) != 0);
          send_symbol(p, q, bad, 16'($urandom), nw, s0, 1'b1);
          force_sof = (nw < 19);
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 1) == 1);
        end
      end
    join
    out_ready = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("rand_drained", exp_q.size(), 0);
    chk("rand_align_count", n_align, m_align);
    chk("rand_sym_cnt", sym_cnt, m_sym);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cyclic_prefix_strip_256.md
# cyclic_prefix_strip_256

Receive-side counterpart of the 256-bit cyclic-prefix inserter. The block accepts a serialized 304-bit OFDM symbol as nineteen 16-bit words: three cyclic-prefix words followed by sixteen body words. It discards the prefix and checks it against the body tail. It then reassembles the body into the 128-bit `phase` / `quad` vectors for the demapper, with valid/ready handshakes on both sides.

## Interface
- `N_CP`, default 3: prefix length in 16-bit words (48 bits).
- `N_BODY`, default 16: body length in words (256 bits).
- `W`, default 16: word width.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `in_data`  in  16: received word.
- `in_valid`  in  1: `in_data` valid.
- `in_sof`  in  1: marks the first prefix word of a symbol; sampled only on an accepted word.
- `in_ready`  out  1: block can accept a word.
- `phase`  out  128: body words 0–7; word 0 is in `[127:112]`.
- `quad`  out  128: body words 8–15; word 8 is in `[127:112]`.
- `out_valid`  out  1: `phase`, `quad` and `cp_err` hold a complete symbol.
- `out_ready`  in  1: downstream accepts the symbol.
- `cp_err`  out  1: prefix mismatch for the presented symbol; qualified by `out_valid`.
- `align_err`  out  1: one-cycle pulse when `in_sof` forces a resync.
- `sym_cnt`  out  16: number of symbols delivered; wraps modulo 2^16.

## Operation
- Transmit format, fixed: symbol = {body[47:0], body}, with body = {phase, quad}. Words are sent MSB-first.
  - The prefix therefore equals body words 13, 14 and 15 (`quad[47:0]`).
- A word is accepted when `in_valid && in_ready`.
- FSM states:
  - `S_CP`: `in_ready`=1. Each accepted word is stored into `cp_buf[idx]` and `idx` increments. When `idx`=`N_CP-1` is accepted, go to `S_BODY` with `idx`=0.
  - `S_BODY`: `in_ready`=1. Each accepted word is shifted into the 256-bit body register.
    - If `idx`≥13, the word is compared to `cp_buf[idx-13]`; any mismatch sets the sticky `err_acc`.
    - When `idx`=15 is accepted, go to `S_OUT`.
  - `S_OUT`: `in_ready`=0 and `out_valid`=1. `phase`, `quad` and `cp_err`=`err_acc` are held stable.
    - On `out_ready`: `sym_cnt`+1, clear `err_acc`, `idx`=0, go to `S_CP`.
- Resync rule for `in_sof`:
  - `in_sof` on an accepted word in `S_BODY`, or in `S_CP` with `idx`≠0, drops the partial symbol.
  - That word is stored as prefix word 0 and the state becomes `S_CP` with `idx`=1. `err_acc` is cleared and `align_err` pulses.
  - `in_sof` is ignored in `S_CP` when `idx`=0.
  - Words arriving without `in_sof` are consumed by position.
- `in_valid` low stalls the FSM in place. There is no timeout.
- Reset values: `in_ready`=0 during reset and 1 from the first cycle after it. `out_valid`=0, `cp_err`=0, `align_err`=0, `sym_cnt`=0, `phase`=0, `quad`=0. FSM is in `S_CP` with `idx`=0.
  - Reset mid-symbol discards all partial data with no output.

## Timing
- `out_valid` rises in the cycle after the 16th body word is accepted. With continuous input, that is 19 accepted cycles + 1 cycle from the first prefix word.
- Back-to-back throughput: 20 cycles per symbol (one bubble while in `S_OUT` with `out_ready` high).
- `out_valid` drops in the cycle after the `out_ready` handshake.
- `in_ready` is registered and low for the whole of `S_OUT`. Output data never changes while `out_valid`=1.
- `cp_err` is valid only with `out_valid`. The compare is registered per word, so there is no combinational path from `in_data` to any output.
- `align_err` is asserted for exactly the cycle after the triggering accept.

## Structure
- A shared package `ofdm_pkg` holds `N_CP`, `N_BODY`, `W`, the FSM state enum and `SYM_W`=304. The package is shared with the inserter.
- One sub-module is natural: `cp_word_cmp`, holding the prefix buffer and the sticky mismatch accumulator. Everything else lives in the top level.

## Test plan
- Vector `phase`=`000a…000a`, `quad`=`0014…0014`, sent as 19 words with `in_sof` on word 0 → `phase`/`quad` reproduced exactly, `cp_err`=0, `sym_cnt`=1.
- All 16 phase/quad combinations from {0005, 000a, 000f, 0014} sent back-to-back with `out_ready`=1 → 16 outputs in order, each 20 cycles apart, all `cp_err`=0, `sym_cnt`=16.
- Second prefix word corrupted to 0013 (`quad` = `0005…`, expected 0005) → output data correct, `cp_err`=1; the next clean symbol gives `cp_err`=0.
- `out_ready` held low for 10 cycles → `in_ready`=0 and outputs stable throughout; the symbol is delivered on release.
- `in_sof` asserted at body word 5, followed by a full clean symbol → `align_err` pulses once, only the clean symbol is output, `cp_err`=0.
- `rst_n` low for one cycle at body word 9 → no output for the partial symbol, `sym_cnt`=0; the following clean symbol is delivered correctly.
